// File: rtl/decoder_onehot_seq_if.sv
// Request/response bundle for decoder_onehot_seq: single decodes, scan
// sweeps and the registered one-hot result.
interface decoder_onehot_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_N = 1 << SEL_W;

  logic             enable;
  logic             in_valid;
  logic [SEL_W-1:0] sel;
  logic             scan_start;
  logic             in_ready;
  logic [OUT_N-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             scan_done;

  modport master (
    output enable, in_valid, sel, scan_start,
    input  in_ready, out, out_valid, busy, scan_done
  );

  modport slave (
    input  enable, in_valid, sel, scan_start,
    output in_ready, out, out_valid, busy, scan_done
  );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered SEL_W -> 2^SEL_W one-hot decoder with a pausable scan mode that
// walks every line once, for write-enable and init-sweep sequencing.
module decoder_onehot_seq #(
  parameter int SEL_W     = 3,
  parameter bit MASK_ZERO = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  decoder_onehot_seq_if.slave  bus
);
  localparam int OUT_N = 1 << SEL_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] count;
  logic [SEL_W-1:0] idx;
  logic [OUT_N-1:0] dec;
  logic [OUT_N-1:0] out_q;
  logic             out_valid_q;
  logic             scan_done_q;

  // One decoder serves both modes: scan walks count, idle decodes sel.
  always_comb idx = (state == SCAN) ? count : bus.sel;

  for (genvar i = 0; i < OUT_N; i++) begin : g_line
    if (MASK_ZERO && i == 0) begin : g_masked
      assign dec[i] = 1'b0;
    end else begin : g_hit
      assign dec[i] = (idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (bus.scan_start) begin
              state <= SCAN;
              count <= '0;
            end else if (bus.in_valid) begin
              out_q       <= dec;
              out_valid_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Stay in SCAN for the scan_done cycle so in_ready rises one later.
          if (scan_done_q) begin
            state <= IDLE;
          end else if (bus.enable) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
            count       <= count + 1'b1;
            if (count == '1) scan_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_done = scan_done_q;
  assign bus.busy      = (state == SCAN);
  assign bus.in_ready  = (state == IDLE);
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench: three decoder configurations driven in lockstep, checked each cycle
// against a step-counting model plus directed literal expectations.
module tb_decoder_onehot_seq;
  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       en      = 1'b0;
  logic       iv      = 1'b0;
  logic       sst     = 1'b0;
  logic [3:0] sel4    = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  decoder_onehot_seq_if #(.SEL_W(3)) if0 ();
  decoder_onehot_seq_if #(.SEL_W(3)) if1 ();
  decoder_onehot_seq_if #(.SEL_W(4)) if2 ();

  assign if0.enable = en;  assign if0.in_valid = iv;  assign if0.scan_start = sst;
  assign if1.enable = en;  assign if1.in_valid = iv;  assign if1.scan_start = sst;
  assign if2.enable = en;  assign if2.in_valid = iv;  assign if2.scan_start = sst;
  assign if0.sel = sel4[2:0];
  assign if1.sel = sel4[2:0];
  assign if2.sel = sel4;

  decoder_onehot_seq #(.SEL_W(3), .MASK_ZERO(1'b0)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
  decoder_onehot_seq #(.SEL_W(3), .MASK_ZERO(1'b1)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  decoder_onehot_seq #(.SEL_W(4), .MASK_ZERO(1'b1)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));

  logic [15:0] d_out [3];
  logic        d_ov [3], d_sd [3], d_busy [3], d_rdy [3];

  assign d_out[0] = {8'h00, if0.out};
  assign d_out[1] = {8'h00, if1.out};
  assign d_out[2] = if2.out;
  assign d_ov[0] = if0.out_valid;  assign d_sd[0] = if0.scan_done;
  assign d_ov[1] = if1.out_valid;  assign d_sd[1] = if1.scan_done;
  assign d_ov[2] = if2.out_valid;  assign d_sd[2] = if2.scan_done;
  assign d_busy[0] = if0.busy;  assign d_rdy[0] = if0.in_ready;
  assign d_busy[1] = if1.busy;  assign d_rdy[1] = if1.in_ready;
  assign d_busy[2] = if2.busy;  assign d_rdy[2] = if2.in_ready;

  function automatic int nlines(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  // Expected line pattern: bit s of an n-line bus, line 0 dark when masked.
  function automatic logic [15:0] line_of(input int k, input int s);
    logic [15:0] one;
    one = 16'd1;
    if (k != 0 && s == 0) return 16'd0;
    return one << s;
  endfunction

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got=%h want=%h @%0t", nm, k, got, exp, $time);
    end
  endtask

  // Model: per config, whether a sweep is running and how many steps it has
  // emitted; steps == n means the sweep finished and one wrap-up cycle remains.
  bit          m_scan [3];
  int          m_step [3];
  logic [15:0] e_out [3];
  bit          e_ov [3], e_sd [3];

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        m_scan[k] = 1'b0; m_step[k] = 0;
        e_out[k] = 16'd0; e_ov[k] = 1'b0; e_sd[k] = 1'b0;
      end else begin
        e_out[k] = 16'd0; e_ov[k] = 1'b0; e_sd[k] = 1'b0;
        if (!m_scan[k]) begin
          if (en && sst) begin
            m_scan[k] = 1'b1; m_step[k] = 0;
          end else if (en && iv) begin
            e_ov[k]  = 1'b1;
            e_out[k] = line_of(k, int'(sel4) % nlines(k));
          end
        end else if (m_step[k] == nlines(k)) begin
          m_scan[k] = 1'b0;
        end else if (en) begin
          e_out[k] = line_of(k, m_step[k]);
          e_ov[k]  = 1'b1;
          e_sd[k]  = (m_step[k] == nlines(k) - 1);
          m_step[k]++;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      chk("out",       k, d_out[k],         e_out[k]);
      chk("out_valid", k, 16'(d_ov[k]),     16'(e_ov[k]));
      chk("scan_done", k, 16'(d_sd[k]),     16'(e_sd[k]));
      chk("busy",      k, 16'(d_busy[k]),   16'(m_scan[k]));
      chk("in_ready",  k, 16'(d_rdy[k]),    16'(!m_scan[k]));
      chk("onehot",    k, 16'($countones(d_out[k]) <= 1), 16'd1);
      chk("done_vld",  k, 16'(!d_sd[k] || d_ov[k]), 16'd1);
    end
  end

  task automatic step(input bit e, input bit v, input bit s, input logic [3:0] sl);
    en = e; iv = v; sst = s; sel4 = sl;
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [15:0] tbl1 [8];
    logic [15:0] one;
    tbl1 = '{16'h00, 16'h02, 16'h04, 16'h08, 16'h10, 16'h20, 16'h40, 16'h80};
    one  = 16'd1;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_out",   0, d_out[0], 16'h0);
    chk("rst_ov",    0, 16'(d_ov[0]), 16'h0);
    chk("rst_sd",    0, 16'(d_sd[0]), 16'h0);
    chk("rst_busy",  2, 16'(d_busy[2]), 16'h0);
    chk("rst_ready", 1, 16'(d_rdy[1]), 16'h1);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // Single decode, then return to zero.
    step(1, 1, 0, 4'd5);
    chk("dec5", 0, d_out[0], 16'h0020);
    chk("dec5_vld", 0, 16'(d_ov[0]), 16'h1);
    step(1, 0, 0, 4'd0);
    chk("dec5_clear", 0, d_out[0], 16'h0000);

    // Full masked sweep.
    step(1, 0, 1, 4'd0);
    chk("scan_busy", 1, 16'(d_busy[1]), 16'h1);
    chk("scan_nrdy", 1, 16'(d_rdy[1]), 16'h0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 4'd0);
      chk("scan_out", 1, d_out[1], tbl1[i]);
      chk("scan_vld", 1, 16'(d_ov[1]), 16'h1);
      chk("scan_done", 1, 16'(d_sd[1]), 16'(i == 7));
    end
    step(1, 0, 0, 4'd0);
    chk("scan_ready_after", 1, 16'(d_rdy[1]), 16'h1);
    repeat (10) step(1, 0, 0, 4'd0);

    // Pause after the 04 step.
    step(1, 0, 1, 4'd0);
    repeat (3) step(1, 0, 0, 4'd0);
    chk("pre_pause", 0, d_out[0], 16'h0004);
    chk("pre_pause", 1, d_out[1], 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'd0);
      chk("pause_out",  0, d_out[0], 16'h0);
      chk("pause_vld",  0, 16'(d_ov[0]), 16'h0);
      chk("pause_busy", 0, 16'(d_busy[0]), 16'h1);
    end
    step(1, 0, 0, 4'd0);
    chk("resume", 0, d_out[0], 16'h0008);
    repeat (20) step(1, 0, 0, 4'd0);

    // scan_start wins over a simultaneous decode; in_valid ignored while scanning.
    step(1, 1, 1, 4'd3);
    chk("simul_nopulse", 0, d_out[0], 16'h0);
    chk("simul_busy", 0, 16'(d_busy[0]), 16'h1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 4'd3);
      chk("simul_scan", 0, d_out[0], one << i);
      chk("simul_nrdy", 0, 16'(d_rdy[0]), 16'h0);
    end
    repeat (20) step(1, 0, 0, 4'd0);

    // Asynchronous reset at count 4.
    step(1, 0, 1, 4'd0);
    repeat (4) step(1, 0, 0, 4'd0);
    chk("pre_reset", 0, d_out[0], 16'h0008);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out",  0, d_out[0], 16'h0);
    chk("arst_busy", 0, 16'(d_busy[0]), 16'h0);
    chk("arst_sd",   0, 16'(d_sd[0]), 16'h0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    step(1, 1, 0, 4'd7);
    chk("post_rst_dec7", 0, d_out[0], 16'h0080);
    chk("post_rst_dec7", 2, d_out[2], 16'h0080);

    // Masked line 0 and top line on the 16-line config, then a 16-step sweep.
    step(1, 1, 0, 4'd0);
    chk("mask0_out", 2, d_out[2], 16'h0);
    chk("mask0_vld", 2, 16'(d_ov[2]), 16'h1);
    chk("nomask0",   0, d_out[0], 16'h0001);
    step(1, 1, 0, 4'd15);
    chk("dec15", 2, d_out[2], 16'h8000);
    step(1, 0, 1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 4'd0);
      chk("scan16_vld",  2, 16'(d_ov[2]), 16'h1);
      chk("scan16_done", 2, 16'(d_sd[2]), 16'(i == 15));
    end
    step(1, 0, 0, 4'd0);
    chk("scan16_ready", 2, 16'(d_rdy[2]), 16'h1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b1;
      end
    end
    repeat (2) step(0, 0, 0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Parametrised, registered successor to the combinational 3-to-8 decoder: decodes a SEL_W-bit select into a 2^SEL_W one-hot vector with one-cycle registered latency, and adds a scan mode that walks the one-hot output across every line for sequenced multi-cycle control. It drives register-file write enables, and it also steps reset/initialisation sweeps across the register file. It adds an enable-based pause and an optional permanent mask on line 0 for hard-wired-zero registers.

## Interface
- SEL_W, 3, select width; OUT_N = 2**SEL_W output lines (derived, not overridable)
- MASK_ZERO, 1, when 1 line 0 is never asserted (sel 0 decodes to all-zero)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global enable; gates acceptance in IDLE, pauses scan in SCAN
- in_valid  in  1  request a single decode of sel this cycle
- sel  in  SEL_W  line to decode, sampled when a request is accepted
- scan_start  in  1  request a full sweep of lines 0..OUT_N-1
- in_ready  out  1  high in IDLE; request is accepted only when in_ready is high
- out  out  OUT_N  registered one-hot (or all-zero) output
- out_valid  out  1  high in the cycle `out` carries a decode result or scan step
- busy  out  1  high in SCAN
- scan_done  out  1  one-cycle pulse coincident with the last scan step

## Operation
- States: IDLE, SCAN. Internal count register, SEL_W bits.
- IDLE, enable=1, scan_start=1: go to SCAN with count=0. This has priority over a simultaneous in_valid, which is dropped and not queued.
- IDLE, enable=1, in_valid=1, scan_start=0: next cycle out=1<<sel and out_valid=1 for exactly one cycle, then out returns to 0. Back-to-back requests give back-to-back pulses.
- IDLE, enable=0: in_valid and scan_start are ignored; out=0, out_valid=0.
- SCAN, enable=1: each cycle out=1<<count and out_valid=1, then count increments.
  - At count=OUT_N-1: scan_done=1 in the same cycle, then the block returns to IDLE. count wraps to 0.
- SCAN, enable=0: pause. count holds, out=0, out_valid=0, busy stays 1. Scan resumes at the held count when enable returns.
- SCAN: in_valid and scan_start are ignored, and in_ready=0.
- MASK_ZERO=1, decode of sel=0 or scan step at count=0: out=0 but out_valid=1. The step still consumes its cycle, so a scan always takes OUT_N enabled cycles.
- out is never more than one-hot. No two lines are ever high in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous release on clock):
  - state=IDLE, count=0
  - out=0, out_valid=0, busy=0, scan_done=0, in_ready=1
- Reset asserted mid-scan: all outputs clear immediately and the scan is abandoned. scan_done does not fire.
- Decode latency: 1 cycle from the accepting edge to out/out_valid.
- Scan latency:
  - First step appears 1 cycle after scan_start is accepted.
  - A full sweep takes OUT_N enabled cycles.
  - in_ready returns the cycle after scan_done.
- in_ready and busy are registered, from the state flop. They are not combinational on inputs.
- scan_done rises only when out_valid is high.

## Test plan
- Setup: SEL_W=3, MASK_ZERO=0.
  - Stimulus: reset_n low, then release; in_valid=1, sel=5, enable=1 for one cycle.
  - Required: next cycle out=8'b0010_0000, out_valid=1; cycle after, out=0.
- Setup: SEL_W=3, MASK_ZERO=1.
  - Stimulus: scan_start with enable held high.
  - Required: out sequence 00,02,04,08,10,20,40,80 (hex) over 8 cycles with out_valid=1 each; scan_done only with 80; in_ready=1 the following cycle.
- Pause test:
  - Stimulus: start a scan; drop enable after the step out=04 (hex) for 3 cycles.
  - Required: out=0, busy=1, out_valid=0 during the pause; on enable high, next step out=08.
- Simultaneous requests:
  - Stimulus: in_valid=1, sel=3 and scan_start=1 in the same IDLE cycle.
  - Required: a scan runs; no separate 08 pulse precedes it. in_valid during SCAN is ignored, and in_ready=0 throughout.
- Reset mid-operation:
  - Stimulus: assert reset_n low asynchronously mid-scan at count=4.
  - Required: out=0, busy=0, scan_done never pulses; after release, a decode of sel=7 gives 80 (hex).
- Setup: SEL_W=4, MASK_ZERO=1.
  - Stimulus: decode sel=0, then sel=15.
  - Required: first gives out=0 with out_valid=1; second gives out=16'h8000. A subsequent scan lasts exactly 16 cycles.
